// File: rtl/opb_master_arbiter.sv
// Two-master arbiter sharing one OPB master port: single-cycle RE/WE strobe, fixed read latency.
// Optional build macro OPB_ARB_FIXED_PRIO_EN gives master 0 strict priority over master 1.
module opb_master_arbiter #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        M0_REQ,
  input  logic        M0_RNW,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_GNT,
  output logic        M0_DONE,
  output logic [31:0] M0_RDATA,
  input  logic        M1_REQ,
  input  logic        M1_RNW,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_GNT,
  output logic        M1_DONE,
  output logic [31:0] M1_RDATA,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  input  logic [31:0] OPB_DI,
  output logic        OPB_RE,
  output logic        OPB_WE,
  output logic        BUSY
);

  // state   | meaning
  // S_IDLE  | sample REQ, select a master, latch its fields
  // S_ISSUE | GNT + single-cycle RE or WE strobe
  // S_WAIT  | read latency countdown, OPB_DI captured on terminal count
  // S_DONE  | DONE pulse to the owning master
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        rnw_q, rnw_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opb_addr_q, opb_addr_d;
  logic [31:0] opb_do_q, opb_do_d;
  logic        opb_re_q, opb_re_d;
  logic        opb_we_q, opb_we_d;
  logic        m0_gnt_q, m0_gnt_d;
  logic        m1_gnt_q, m1_gnt_d;
  logic        m0_done_q, m0_done_d;
  logic        m1_done_q, m1_done_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        busy_q, busy_d;
  logic        pick;
  logic        pick_rnw;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rnw_d        = rnw_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    opb_addr_d   = opb_addr_q;
    opb_do_d     = opb_do_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    opb_re_d     = 1'b0;
    opb_we_d     = 1'b0;
    m0_gnt_d     = 1'b0;
    m1_gnt_d     = 1'b0;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
`ifdef OPB_ARB_FIXED_PRIO_EN
    pick = ~M0_REQ;
`else
    pick = (M0_REQ && M1_REQ) ? ~last_grant_q : M1_REQ;
`endif
    pick_rnw = pick ? M1_RNW : M0_RNW;

    case (state_q)
      S_IDLE: begin
        if (M0_REQ || M1_REQ) begin
          sel_d        = pick;
          rnw_d        = pick_rnw;
          last_grant_d = pick;
          opb_addr_d   = pick ? M1_ADDR : M0_ADDR;
          opb_do_d     = pick ? M1_WDATA : M0_WDATA;
          // outputs are registered, so ISSUE's strobe and GNT are set on entry
          opb_re_d     = pick_rnw;
          opb_we_d     = ~pick_rnw;
          m0_gnt_d     = ~pick;
          m1_gnt_d     = pick;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rnw_q) begin
          cnt_d   = LAT_INIT;
          state_d = S_WAIT;
        end else begin
          m0_done_d = ~sel_q;
          m1_done_d = sel_q;
          state_d   = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          if (sel_q) m1_rdata_d = OPB_DI;
          else       m0_rdata_d = OPB_DI;
          m0_done_d = ~sel_q;
          m1_done_d = sel_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      rnw_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      opb_addr_q   <= 32'd0;
      opb_do_q     <= 32'd0;
      opb_re_q     <= 1'b0;
      opb_we_q     <= 1'b0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rnw_q        <= rnw_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      opb_addr_q   <= opb_addr_d;
      opb_do_q     <= opb_do_d;
      opb_re_q     <= opb_re_d;
      opb_we_q     <= opb_we_d;
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign M0_GNT   = m0_gnt_q;
  assign M1_GNT   = m1_gnt_q;
  assign M0_DONE  = m0_done_q;
  assign M1_DONE  = m1_done_q;
  assign M0_RDATA = m0_rdata_q;
  assign M1_RDATA = m1_rdata_q;
  assign OPB_ADDR = opb_addr_q;
  assign OPB_DO   = opb_do_q;
  assign OPB_RE   = opb_re_q;
  assign OPB_WE   = opb_we_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Bench for opb_master_arbiter: transaction table, OPB slave model and strobe/done scoreboard.
// Expected grant order follows OPB_ARB_FIXED_PRIO_EN when the build defines it.
module tb_opb_master_arbiter;
  localparam int RD_LAT = 3;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic        M0_REQ = 1'b0, M0_RNW = 1'b0, M1_REQ = 1'b0, M1_RNW = 1'b0;
  logic [31:0] M0_ADDR = '0, M0_WDATA = '0, M1_ADDR = '0, M1_WDATA = '0;
  logic        M0_GNT, M0_DONE, M1_GNT, M1_DONE, OPB_RE, OPB_WE, BUSY;
  logic [31:0] M0_RDATA, M1_RDATA, OPB_ADDR, OPB_DO;
  logic [31:0] OPB_DI = '0;

  opb_master_arbiter #(.RD_LATENCY(RD_LAT)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST),
    .M0_REQ(M0_REQ), .M0_RNW(M0_RNW), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_GNT(M0_GNT), .M0_DONE(M0_DONE), .M0_RDATA(M0_RDATA),
    .M1_REQ(M1_REQ), .M1_RNW(M1_RNW), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_GNT(M1_GNT), .M1_DONE(M1_DONE), .M1_RDATA(M1_RDATA),
    .OPB_ADDR(OPB_ADDR), .OPB_DO(OPB_DO), .OPB_DI(OPB_DI),
    .OPB_RE(OPB_RE), .OPB_WE(OPB_WE), .BUSY(BUSY)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  typedef struct {
    bit          m;
    bit          rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    bit          m;
    bit          rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_done;
  } vec_t;

  txn_t        sb_exp[$];
  txn_t        sb_done[$];
  int          gnt_log[$];
  int          n_total = 0, n_pass = 0, n_strobe = 0, cyc = 0, di_cnt = -1;
  logic [31:0] rd_model [2];
  vec_t        vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] slave_val(input logic [31:0] a);
    if (a == 32'h20) return 32'h1234_5678;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  always @(posedge OPB_CLK) cyc++;

  // Slave: read data valid only RD_LAT cycles after the RE cycle, garbage otherwise.
  always @(posedge OPB_CLK) begin
    #1;
    if (OPB_RE) di_cnt = RD_LAT;
    else if (di_cnt >= 0) di_cnt--;
    OPB_DI = (di_cnt == 0) ? slave_val(OPB_ADDR) : 32'hBAD0_0BAD;
  end

  always @(negedge OPB_CLK) begin
    txn_t e;
    check("exclusive", {61'd0, M0_GNT & M1_GNT, M0_DONE & M1_DONE, OPB_RE & OPB_WE}, 64'd0);
    if (OPB_RE || OPB_WE) begin
      n_strobe++;
      if (sb_exp.size() == 0) check("unexpected_strobe", 64'd1, 64'd0);
      else begin
        e = sb_exp.pop_front();
        check("gnt_owner", {62'd0, M1_GNT, M0_GNT}, e.m ? 64'd2 : 64'd1);
        check("opb_addr", OPB_ADDR, e.addr);
        check("opb_do", OPB_DO, e.wdata);
        check("opb_re", OPB_RE, e.rnw);
        check("opb_we", OPB_WE, !e.rnw);
        sb_done.push_back(e);
        gnt_log.push_back(cyc);
      end
    end
    if (M0_DONE || M1_DONE) begin
      if (sb_done.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb_done.pop_front();
        check("done_owner", {62'd0, M1_DONE, M0_DONE}, e.m ? 64'd2 : 64'd1);
        if (e.rnw) check("done_rdata", e.m ? M1_RDATA : M0_RDATA, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge OPB_CLK); #1;
  endtask

  task automatic drive_req(input bit m, input bit on, input bit rnw,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin M1_REQ = on; M1_RNW = rnw; M1_ADDR = addr; M1_WDATA = wdata; end
    else   begin M0_REQ = on; M0_RNW = rnw; M0_ADDR = addr; M0_WDATA = wdata; end
  endtask

  task automatic apply_reset();
    OPB_RST = 1'b1;
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    sb_exp.delete(); sb_done.delete();
    repeat (2) tick();
    OPB_RST = 1'b0;
    rd_model[0] = '0; rd_model[1] = '0;
  endtask

  task automatic push_exp(input bit m, input bit rnw, input logic [31:0] addr,
                          input logic [31:0] wdata);
    txn_t t;
    t.m = m; t.rnw = rnw; t.addr = addr; t.wdata = wdata;
    t.rdata = rnw ? slave_val(addr) : rd_model[m];
    sb_exp.push_back(t);
  endtask

  task automatic wait_gnt(input bit m, output int gc);
    bit got = 0;
    gc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge OPB_CLK);
      if (m ? M1_GNT : M0_GNT) begin got = 1; gc = cyc; end
    end
    check("gnt_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic do_xfer(input bit m, input bit rnw, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_done);
    int c0, gc, dc, s0;
    bit got = 0;
    dc = -1;
    push_exp(m, rnw, addr, wdata);
    s0 = n_strobe;
    c0 = cyc;
    drive_req(m, 1'b1, rnw, addr, wdata);
    wait_gnt(m, gc);
    tick();
    drive_req(m, 1'b0, rnw, addr, wdata);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge OPB_CLK);
      if (m ? M1_DONE : M0_DONE) begin got = 1; dc = cyc; end
    end
    check("gnt_latency", 64'(gc - c0), 64'd1);
    check("done_latency", 64'(dc - c0), 64'(exp_done));
    if (rnw) rd_model[m] = slave_val(addr);
    check("m0_rdata", M0_RDATA, rd_model[0]);
    check("m1_rdata", M1_RDATA, rd_model[1]);
    check("one_strobe", 64'(n_strobe - s0), 64'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0, gc;
    vecs[0] = '{m: 1'b0, rnw: 1'b0, addr: 32'h10, wdata: 32'hDEAD_BEEF, exp_done: 2};
    vecs[1] = '{m: 1'b1, rnw: 1'b1, addr: 32'h20, wdata: 32'h0,         exp_done: 2 + RD_LAT};
    vecs[2] = '{m: 1'b0, rnw: 1'b1, addr: 32'h44, wdata: 32'h5555_AAAA, exp_done: 2 + RD_LAT};
    vecs[3] = '{m: 1'b1, rnw: 1'b0, addr: 32'h24, wdata: 32'hCAFE_F00D, exp_done: 2};
    vecs[4] = '{m: 1'b0, rnw: 1'b1, addr: 32'h20, wdata: 32'h0,         exp_done: 2 + RD_LAT};
    vecs[5] = '{m: 1'b1, rnw: 1'b1, addr: 32'h80, wdata: 32'h1,         exp_done: 2 + RD_LAT};

    apply_reset();
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_ctl", {58'd0, M0_GNT, M1_GNT, M0_DONE, M1_DONE, OPB_RE, OPB_WE}, 64'd0);
    check("rst_opb", {OPB_ADDR, OPB_DO}, 64'd0);
    check("rst_rdata", {M0_RDATA, M1_RDATA}, 64'd0);

    foreach (vecs[i])
      do_xfer(vecs[i].m, vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_done);

    // Both masters write continuously from reset.
    apply_reset();
`ifdef OPB_ARB_FIXED_PRIO_EN
    push_exp(1'b0, 1'b0, 32'h100, 32'h1111_0000);
    push_exp(1'b0, 1'b0, 32'h100, 32'h1111_0000);
    push_exp(1'b0, 1'b0, 32'h100, 32'h1111_0000);
    push_exp(1'b1, 1'b0, 32'h200, 32'h2222_0000);
`else
    for (int k = 0; k < 4; k++)
      push_exp(k[0], 1'b0, k[0] ? 32'h200 : 32'h100, k[0] ? 32'h2222_0000 : 32'h1111_0000);
`endif
    g0 = gnt_log.size();
    drive_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h1111_0000);
    drive_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h2222_0000);
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge OPB_CLK);
      if (M0_GNT || M1_GNT) begin
        n++;
        tick();
`ifdef OPB_ARB_FIXED_PRIO_EN
        if (n == 3) M0_REQ = 1'b0;
`endif
        if (n == 4) begin M0_REQ = 1'b0; M1_REQ = 1'b0; end
      end
    end
    check("arb_grants", 64'(n), 64'd4);
    for (int i = 0; i < 20 && sb_done.size() != 0; i++) tick();
    check("arb_all_done", 64'(sb_exp.size() + sb_done.size()), 64'd0);
    if (gnt_log.size() >= g0 + 4)
      for (int k = 1; k < 4; k++)
        check("arb_spacing", 64'(gnt_log[g0 + k] - gnt_log[g0 + k - 1]), 64'd3);
    else check("arb_log", 64'(gnt_log.size() - g0), 64'd4);
    repeat (2) tick();

    // Reset in the middle of a read's WAIT phase.
    do_xfer(1'b1, 1'b1, 32'h60, 32'h0, 2 + RD_LAT);
    push_exp(1'b0, 1'b1, 32'h48, 32'h0);
    drive_req(1'b0, 1'b1, 1'b1, 32'h48, 32'h0);
    wait_gnt(1'b0, gc);
    tick();
    M0_REQ = 1'b0;
    tick();
    OPB_RST = 1'b1;
    sb_done.delete();
    tick();
    OPB_RST = 1'b0;
    check("mid_rst_busy", {63'd0, BUSY}, 64'd0);
    check("mid_rst_ctl", {58'd0, M0_GNT, M1_GNT, M0_DONE, M1_DONE, OPB_RE, OPB_WE}, 64'd0);
    check("mid_rst_rdata", {M0_RDATA, M1_RDATA}, 64'd0);
    rd_model[0] = '0; rd_model[1] = '0;
    repeat (6) tick();
    check("mid_rst_idle", {63'd0, BUSY}, 64'd0);
    do_xfer(1'b1, 1'b1, 32'h20, 32'h0, 2 + RD_LAT);

    // REQ held one cycle past GNT must still yield a single strobe.
    n = n_strobe;
    push_exp(1'b1, 1'b0, 32'h300, 32'h3333_3333);
    drive_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h3333_3333);
    wait_gnt(1'b1, gc);
    tick();
    tick();
    M1_REQ = 1'b0;
    repeat (8) tick();
    check("held_req_strobes", 64'(n_strobe - n), 64'd1);
    check("held_req_drained", 64'(sb_exp.size() + sb_done.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/opb_master_arbiter.md
Name: opb_master_arbiter

Overview:
Two-master arbiter that shares the single OPB master port between the message-driven OPB emulator (master 0) and a second internal requester (master 1), e.g. a periodic status poller.
- Accepts one request at a time, issues a single-cycle OPB_RE/OPB_WE strobe, waits a fixed read latency, captures OPB_DI and signals completion to the owning master.
- Sits between the requesters and the OPB slave decode, on OPB_CLK.

Parameters:
RD_LATENCY, 1, cycles from the OPB_RE strobe cycle to the cycle in which OPB_DI is valid (legal range 1..15)

Ports:
OPB_CLK  in  1  system clock
OPB_RST  in  1  synchronous reset, active high
M0_REQ  in  1  master 0 request, level; fields below must be stable while high
M0_RNW  in  1  1 = read, 0 = write
M0_ADDR  in  32  master 0 address
M0_WDATA  in  32  master 0 write data
M0_GNT  out  1  one-cycle accept pulse to master 0
M0_DONE  out  1  one-cycle completion pulse to master 0
M0_RDATA  out  32  read data for master 0, valid with M0_DONE, held until next M0 read completes
M1_REQ, M1_RNW, M1_ADDR, M1_WDATA, M1_GNT, M1_DONE, M1_RDATA  same as M0_*, for master 1
OPB_ADDR  out  32  OPB address
OPB_DO  out  32  OPB write data
OPB_DI  in  32  OPB read data
OPB_RE  out  1  OPB read strobe
OPB_WE  out  1  OPB write strobe
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset state: IDLE. All outputs 0; last_grant = 1, so master 0 wins the first tie.
- All outputs are registered.
- IDLE: REQ is sampled only in this state.
  - Neither REQ high: remain in IDLE.
  - One REQ high: select that master.
  - Both REQ high: select the master that is not last_grant (round-robin).
  - On selection: latch RNW, ADDR and WDATA; load OPB_ADDR and OPB_DO; update last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - Mx_GNT = 1 for the selected master.
  - OPB_WE = 1 if the transfer is a write, OPB_RE = 1 if it is a read.
  - Write: next state DONE. Read: load the wait counter with RD_LATENCY and go to WAIT.
- WAIT (RD_LATENCY cycles):
  - Decrement the counter each cycle.
  - In the last WAIT cycle, capture OPB_DI into the selected master's Mx_RDATA register.
  - Then go to DONE.
- DONE (1 cycle): Mx_DONE = 1 for the selected master; next state IDLE.
- Master rule: drop REQ, or present a new request, on the edge following the GNT cycle. The arbiter re-samples REQ only in IDLE, so a granted request is never issued twice.
- OPB_ADDR and OPB_DO hold their values until the next selection. Strobes are high only in ISSUE.
- The other master's RDATA is untouched.
- Latency from the edge that samples REQ:
  - Write: GNT and WE in cycle 1, DONE in cycle 2.
  - Read: GNT and RE in cycle 1, DONE in cycle 2+RD_LATENCY.
  - Minimum spacing between back-to-back transfers: write 3 cycles, read 3+RD_LATENCY cycles.
- A master's request that loses arbitration stays pending. With both masters requesting continuously, grants alternate M0, M1, M0, …
- Reset mid-operation: return to IDLE on the next edge and clear strobes, GNT, DONE and BUSY. The in-flight transfer is dropped with no DONE; RDATA registers are cleared.
- GNT and DONE are never high for both masters at once. RE and WE are never high together.

Optional Feature:
OPB_ARB_FIXED_PRIO_EN
- Defined: master 0 always wins when both REQ are high; master 1 is granted only when M0_REQ is low in the IDLE sample cycle. last_grant is still maintained but not used.
- Undefined: round-robin as specified above.

Test Plan:
- Write from M0 (ADDR=0x0000_0010, WDATA=0xDEAD_BEEF) with M1 idle -> OPB_WE=1 for exactly one cycle with that address and data; M0_GNT in cycle 1; M0_DONE in cycle 2; no M1 outputs.
- Read from M1 (ADDR=0x0000_0020), RD_LATENCY=3, OPB_DI driven 0x1234_5678 in the third cycle after RE -> M1_DONE in cycle 5; M1_RDATA=0x1234_5678; M0_RDATA unchanged.
- M0 and M1 both request a write in the same cycle from reset, held continuously -> grant order M0, M1, M0, M1 (verify 4 transfers; each OPB_ADDR matches the granted master).
- Same stimulus with OPB_ARB_FIXED_PRIO_EN defined and M0_REQ held high -> only M0 granted; M1 is granted in the first IDLE sample after M0_REQ drops.
- Assert OPB_RST during WAIT of a read -> next cycle BUSY=0 and all strobes and GNT/DONE low; no DONE pulse; M0_RDATA and M1_RDATA = 0; a new request afterwards completes normally.
- Master keeps REQ high one cycle after GNT, then drops it -> exactly one OPB strobe issued for that request.
